// File: rtl/fpadd_norm_round.sv
// Normalize-and-round back end of an FP32 adder: takes the raw significand sum,
// renormalizes it one bit per cycle, rounds to nearest-even and holds the result for the consumer.
module fpadd_norm_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [25:0] sum_q, sum_d;   // carry is folded away on accept: [25] hidden .. [0] sticky
    logic [31:0] out_q, out_d;
    logic [30:0] rnd;

    // Round-to-nearest-even on {frac[24:2], guard[1], sticky[0]}; returns {exp, frac}.
    function automatic logic [30:0] round_rne(input logic [7:0] e_in, input logic [24:0] grs);
        logic        inc;
        logic [23:0] frac_inc;
        inc      = grs[1] & (grs[0] | grs[2]);
        frac_inc = {1'b0, grs[24:2]} + {23'd0, inc};
        if (frac_inc[23])
            return {e_in + 8'd1, 23'd0};
        return {e_in, frac_inc[22:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sum_d   = sum_q;
        out_d   = out_q;
        rnd     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = in_exp;
                    sum_d  = in_sum[25:0];
                    if (in_sum == 27'd0) begin
                        sign_d  = 1'b0;
                        out_d   = 32'd0;
                        state_d = DONE;
                    end else if (in_sum[26]) begin
                        sum_d   = {in_sum[26:2], in_sum[1] | in_sum[0]};
                        exp_d   = in_exp + 8'd1;
                        state_d = ROUND;
                    end else if (in_sum[25]) begin
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Sticky stays put as an OR so shifting never loses it.
                sum_d = {sum_q[24:0], 1'b0} | {25'd0, sum_q[0]};
                exp_d = exp_q - 8'd1;
                if (sum_q[24])
                    state_d = ROUND;
            end
            ROUND: begin
                rnd     = round_rne(exp_q, sum_q[24:0]);
                exp_d   = rnd[30:23];
                out_d   = {sign_q, rnd};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        sum_q  <= sum_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;

endmodule

// File: doc/fpadd_norm_round.md
FPADD_NORM_ROUND -- requirements
Module: fpadd_norm_round

Interface
REQ-001 SHALL have no parameters; the format is fixed to FP32 (1 sign, 8 exponent biased by 127, 23 fraction bits).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an unnormalized sum is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an input this cycle.
REQ-006 SHALL have port in_sign, input, 1 bit: sign of the result.
REQ-007 SHALL have port in_exp, input, 8 bits: exponent of the larger operand.
REQ-008 SHALL have port in_sum, input, 27 bits: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
REQ-009 SHALL have port out_valid, output, 1 bit: out holds a final result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes out this cycle.
REQ-011 SHALL have port out, output, 32 bits: rounded FP32 result.
REQ-012 SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, ROUND and DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL, on an accept in IDLE (in_valid & in_ready), register the sign, exponent and sum.
REQ-015 SHALL, on an accept, take exactly one of these paths:
- in_sum == 0: go to DONE with out = 32'h00000000, sign forced to 0.
- in_sum[26] = 1: shift the sum right by 1, set exp + 1, OR the bit shifted out into sticky, go to ROUND.
- in_sum[25] = 1: go to ROUND.
- otherwise: go to SHIFT.
REQ-016 SHALL, in SHIFT, shift the sum left by 1 and decrement exp by 1 each cycle (zero enters bit 0, sticky is preserved as OR), and go to ROUND in the cycle after bit 25 becomes 1.
REQ-017 SHALL, in ROUND, use round-to-nearest-even: increment the fraction when guard & (sticky | fraction LSB); on fraction overflow, set fraction = 0 and exp + 1; then go to DONE.
REQ-018 SHALL, in DONE, drive out_valid = 1 with out = {sign, exp, fraction}, holding both stable until out_ready = 1, then go to IDLE.
REQ-019 SHALL NOT accept a new input in the same cycle as a DONE handshake; the next accept is possible at the earliest one cycle later.
REQ-020 SHALL have latency, measured from the accept edge to the edge that sets out_valid:
- 2 cycles for a normalized sum or a carry sum.
- 2 + n cycles for n leading zeros above the hidden bit.
- 1 cycle for a zero sum.
REQ-021 SHALL perform no exponent underflow or overflow checking; the exponent stays within 1..254 and wraps modulo 256 otherwise.
REQ-022 SHALL change out only on entry to DONE; out holds its last value while in IDLE.
REQ-023 SHALL ignore in_* whenever in_ready = 0.

Reset
REQ-024 SHALL, on reset assertion, go immediately to IDLE with out = 0, out_valid = 0, busy = 0 and in_ready = 1 after release, independent of clk.
REQ-025 SHALL, on reset in SHIFT, ROUND or DONE, discard the in-flight operation; no out_valid pulse follows.

Verification
REQ-026 SHALL be verified with a carry sum: sign 0, exp 127, in_sum = 27'h4000000 (1.0+1.0) -> out = 32'h40000000 with out_valid 2 cycles after accept.
REQ-027 SHALL be verified for ties-to-even:
- exp 127, hidden 1, fraction 0, guard 1, sticky 0 -> out = 32'h3F800000.
- the same with fraction LSB 1 -> out = 32'h3F800002.
REQ-028 SHALL be verified with cancellation: exp 130, in_sum = 27'h0400000 (only bit 22 set) -> 3 SHIFT cycles, out = 32'h3F800000, out_valid 5 cycles after accept.
REQ-029 SHALL be verified with a zero sum and rounding overflow:
- sign 1, in_sum = 0 -> out = 32'h00000000 after 1 cycle.
- exp 127, hidden 1, fraction all ones, guard 1, sticky 1 -> out = 32'h40000000.
REQ-030 SHALL be verified under backpressure: hold out_ready = 0 for 4 cycles in DONE -> out and out_valid stay stable and in_ready = 0; the handshake completes on the first out_ready = 1.
REQ-031 SHALL be verified with reset mid-operation: assert reset during the 2nd SHIFT cycle of the REQ-028 stimulus -> out = 0, out_valid = 0 immediately, and the next input is processed correctly.
